fifo_rd_port: RTL and testbench
===============================

Name: fifo_rd_port

Overview:
- Read-side controller for the shared-clock FIFO, the consumer counterpart of the write/occupancy logic.
- Owns the read pointer and fetches words from the FIFO's synchronous RAM (1-cycle read latency).
- Presents data on a valid/ready stream through a 2-entry output buffer, so it sustains one word per cycle.
- Exports the read pointer to the write side, which uses it to compute full/count.

Parameters:
- DATA_W, 8, word width.
- ADDR_W, 8, RAM address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits (MSB = wrap bit).
- AE_THRESH, 4, almost-empty threshold (used only with the optional feature).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_ptr  in  ADDR_W+1  registered write pointer from the write side (binary, same clock).
- rd_ptr  out  ADDR_W+1  fetch pointer; slot is released to the writer once fetched.
- mem_ren  out  1  RAM read enable.
- mem_raddr  out  ADDR_W  RAM read address = rd_ptr[ADDR_W-1:0].
- mem_rdata  in  DATA_W  RAM data, valid the cycle after mem_ren.
- rd_valid  out  1  output word available.
- rd_ready  in  1  consumer accepts.
- rd_data  out  DATA_W  output word (head of buffer).
- level  out  ADDR_W+1  words held = (wr_ptr - rd_ptr) mod 2**(ADDR_W+1) + buf_cnt + inflight.
- almost_empty  out  1  only with FIFO_RD_AE_EN.

Behaviour:
- Reset (async assert, sync release): rd_ptr=0, buf_cnt=0, inflight=0, rd_valid=0, rd_data=0, mem_ren=0, level=0, almost_empty=1.
- avail = (wr_ptr != rd_ptr). Pointer equality means empty, and only equality; the wrap bit distinguishes full from empty on the write side.
- pop = rd_valid & rd_ready.
- Fetch rule: mem_ren = avail & (buf_cnt + inflight - pop < 2). This is combinational from registered state and rd_ready.
- On mem_ren: rd_ptr <= rd_ptr+1, wrapping mod 2**(ADDR_W+1); inflight <= 1 next cycle.
- inflight=1: mem_rdata is written into the buffer that cycle. The buffer never overflows by construction; overflow is an assertion.
- Buffer: 2-entry FIFO (head/tail registers). rd_data = head, rd_valid = (buf_cnt != 0).
- Fill and pop in the same cycle: buf_cnt unchanged; the new word lands behind the remaining entry, or at head if the buffer empties.
- Latency: wr_ptr advances in cycle t → mem_ren in t → rd_valid in t+2.
- Throughput: with rd_ready held high, one word per cycle continuously.
- rd_valid stays asserted while rd_ready=0, and rd_data is stable until pop.
- Only the pointer crosses to the write side; the RAM is never written by this block.
- Reset mid-stream discards buffered and in-flight words. The write side must reset together with this block.
- wr_ptr decreasing or exceeding rd_ptr by more than the depth is illegal; this is an assertion, not handled.
- level is registered from next-state values, so it is consistent the same cycle as pointers.

Optional Feature:
- Macro FIFO_RD_AE_EN.
- Defined: almost_empty port exists and is registered, = (level_next <= AE_THRESH).
- Undefined: port absent, no comparator logic; level is still present.

Decomposition:
- Package fifo_pkg holds:
  - the ptr_t typedef (ADDR_W+1 bits);
  - the ptr_diff function (modular subtraction);
  - constants DEPTH and BUF_DEPTH=2.
- One natural sub-module: fifo_rd_skid (the 2-entry output buffer with push/pop/cnt). Pointer and fetch logic stays in the top.

Test Plan:
- Reset then wr_ptr=0 → rd_valid=0, mem_ren=0, rd_ptr=0, level=0, almost_empty=1.
- wr_ptr 0→1 at cycle 5, RAM[0]=0xA5, rd_ready=1 → mem_ren cycle 5; rd_valid, rd_data=0xA5 cycle 7; rd_ptr=1; level returns to 0.
- wr_ptr=8 with data 0..7, rd_ready=1 → 8 consecutive valid cycles with data 0..7, no bubbles.
- Same with rd_ready=0 → exactly 2 fetches, rd_ptr=2, level=8, rd_data=0 held stable. Raise ready → remaining words in order.
- Wrap: rd_ptr=0x1FE, wr_ptr=0x002 → 4 words from addresses 0xFE, 0xFF, 0x00, 0x01; rd_ptr ends 0x002.
- Assert rst_n=0 mid-burst with buf_cnt=2 → immediate rd_valid=0, rd_ptr=0. FIFO_RD_AE_EN with AE_THRESH=4, level 5→4 → almost_empty rises that cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and constants for the shared-clock FIFO read/write sides.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_W    = 8;
  localparam int unsigned FIFO_ADDR_W    = 8;
  localparam int unsigned FIFO_AE_THRESH = 4;

  localparam int unsigned DEPTH     = 1 << FIFO_ADDR_W;
  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned PTR_W     = FIFO_ADDR_W + 1;
  localparam int unsigned CNT_W     = 2;

  // Pointer with wrap bit in the MSB.
  typedef logic [PTR_W-1:0] ptr_t;

  // Modular distance a - b; equal pointers mean empty.
  function automatic ptr_t ptr_diff(input ptr_t a, input ptr_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer (head/tail) feeding the read stream.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  cnt
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == CNT_W'(0)) head_d = push_data;
        else                    tail_d = push_data;
        cnt_d = cnt_q + CNT_W'(1);
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - CNT_W'(1);
      end
      2'b11: begin
        // New word goes behind the survivor, or straight to head if none remains.
        if (cnt_q == CNT_W'(BUF_DEPTH)) begin
          head_d = tail_q;
          tail_d = push_data;
        end else begin
          head_d = push_data;
        end
      end
      default: ;
    endcase
    valid_d = (cnt_d != CNT_W'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;
  assign head  = head_q;
  assign cnt   = cnt_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && cnt_q == CNT_W'(BUF_DEPTH)));

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && cnt_q == CNT_W'(0)));

endmodule

// File: rtl/fifo_rd_port.sv
// FIFO read-side controller: read pointer, RAM fetch, 2-deep output stream.
// Optional almost_empty output is enabled by defining FIFO_RD_AE_EN.
module fifo_rd_port
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = FIFO_DATA_W,
  parameter int unsigned ADDR_W    = FIFO_ADDR_W,
  parameter int unsigned AE_THRESH = FIFO_AE_THRESH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   wr_ptr,
  output logic [ADDR_W:0]   rd_ptr,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   level
`ifdef FIFO_RD_AE_EN
  ,
  output logic              almost_empty
`endif
);

  // Pointer types come from the package, so the widths must agree.
  if (ADDR_W != FIFO_ADDR_W || AE_THRESH > DEPTH) begin : g_param_check
    $error("fifo_rd_port: ADDR_W must match fifo_pkg and AE_THRESH must not exceed DEPTH");
  end

  ptr_t             rd_ptr_q, rd_ptr_d;
  ptr_t             level_q, level_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] buf_cnt, buf_cnt_next;
  logic             buf_valid;
  logic [DATA_W-1:0] buf_head;
  logic             pop;
  logic             avail;
  logic             fetch;
  logic [2:0]       occ;

  // Fetch only when the word can be guaranteed a buffer slot on arrival.
  always_comb begin
    pop          = buf_valid & rd_ready;
    avail        = (ptr_t'(wr_ptr) != rd_ptr_q);
    occ          = 3'(buf_cnt) + 3'(inflight_q);
    fetch        = avail && (occ < (3'd2 + 3'(pop)));
    rd_ptr_d     = rd_ptr_q + PTR_W'(fetch);
    inflight_d   = fetch;
    buf_cnt_next = CNT_W'(occ - 3'(pop));
    level_d      = ptr_diff(ptr_t'(wr_ptr), rd_ptr_d)
                 + PTR_W'(buf_cnt_next) + PTR_W'(inflight_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      level_q    <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      level_q    <= level_d;
    end
  end

  fifo_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (mem_rdata),
    .pop       (pop),
    .valid     (buf_valid),
    .head      (buf_head),
    .cnt       (buf_cnt)
  );

  assign rd_ptr    = rd_ptr_q;
  assign mem_ren   = fetch;
  assign mem_raddr = rd_ptr_q[ADDR_W-1:0];
  assign rd_valid  = buf_valid;
  assign rd_data   = buf_head;
  assign level     = level_q;

`ifdef FIFO_RD_AE_EN
  logic ae_q, ae_d;

  always_comb begin
    ae_d = (level_d <= PTR_W'(AE_THRESH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ae_q <= 1'b1;
    else        ae_q <= ae_d;
  end

  assign almost_empty = ae_q;
`endif

  // Write pointer must never run backwards or lap the reader.
  a_ptr_window : assert property (@(posedge clk) disable iff (!rst_n)
    ptr_diff(ptr_t'(wr_ptr), rd_ptr_q) <= PTR_W'(DEPTH));

  a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (rd_valid && !rd_ready) |=> (rd_valid && $stable(rd_data)));

endmodule

// File: tb/tb_fifo_rd_port.sv
// Directed bench for fifo_rd_port: vector table plus multi-cycle sequences.
module tb_fifo_rd_port;

  logic       clk;
  logic       rst_n;
  logic [8:0] wr_ptr;
  logic [8:0] rd_ptr;
  logic       mem_ren;
  logic [7:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic [8:0] level;
`ifdef FIFO_RD_AE_EN
  logic       almost_empty;
`endif

  logic [7:0] ram [256];

  int errors = 0;
  int checks = 0;

  fifo_rd_port dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .mem_ren      (mem_ren),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .level        (level)
`ifdef FIFO_RD_AE_EN
    ,
    .almost_empty (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= ram[mem_raddr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream everything up to target with ready high, bounded.
  task automatic drain(input logic [8:0] target);
    bit done;
    done = 0;
    step();
    wr_ptr   = target;
    rd_ready = 1'b1;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk);
      if (rd_ptr == target && !rd_valid && level == 9'd0) done = 1;
      else step();
    end
    chk("drain_done", 32'(done), 32'd1);
    chk("drain_rd_ptr", 32'(rd_ptr), 32'(target));
  endtask

  typedef struct {
    logic [8:0] wr_ptr;
    logic       rd_ready;
    logic       exp_ren;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [8:0] exp_rd_ptr;
    logic [8:0] exp_level;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [7:0] exp_addr [4];
    logic [7:0] exp_wdat [4];
    logic [7:0] got_addr [$];
    logic [7:0] got_data [$];
    int got, bubbles;
    bit started;

    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[0] = 8'hA5;
    for (int i = 0; i < 8; i++) ram[1 + i] = 8'(i);
    for (int i = 0; i < 8; i++) ram[9 + i] = 8'(i);

    // Single word: wr_ptr steps 0->1 in cycle 5, data visible in cycle 7.
    for (int i = 0; i < 5; i++) vecs[i] = '{9'd0, 1'b1, 1'b0, 1'b0, 8'h00, 9'd0, 9'd0};
    vecs[5] = '{9'd1, 1'b1, 1'b1, 1'b0, 8'h00, 9'd0, 9'd0};
    vecs[6] = '{9'd1, 1'b1, 1'b0, 1'b0, 8'h00, 9'd1, 9'd1};
    vecs[7] = '{9'd1, 1'b1, 1'b0, 1'b1, 8'hA5, 9'd1, 9'd1};
    vecs[8] = '{9'd1, 1'b1, 1'b0, 1'b0, 8'h00, 9'd1, 9'd0};
    vecs[9] = '{9'd1, 1'b1, 1'b0, 1'b0, 8'h00, 9'd1, 9'd0};

    rst_n    = 1'b0;
    wr_ptr   = 9'd0;
    rd_ready = 1'b0;
    #23;
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_mem_ren",  32'(mem_ren),  32'd0);
    chk("reset_rd_ptr",   32'(rd_ptr),   32'd0);
    chk("reset_level",    32'(level),    32'd0);
    chk("reset_rd_data",  32'(rd_data),  32'd0);
`ifdef FIFO_RD_AE_EN
    chk("reset_almost_empty", 32'(almost_empty), 32'd1);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step();
      wr_ptr   = vecs[i].wr_ptr;
      rd_ready = vecs[i].rd_ready;
      @(negedge clk);
      chk($sformatf("vec%0d_mem_ren", i),  32'(mem_ren),  32'(vecs[i].exp_ren));
      chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_rd_ptr", i),   32'(rd_ptr),   32'(vecs[i].exp_rd_ptr));
      chk($sformatf("vec%0d_level", i),    32'(level),    32'(vecs[i].exp_level));
      chk($sformatf("vec%0d_raddr", i),    32'(mem_raddr), 32'(vecs[i].exp_rd_ptr[7:0]));
    end

    // Eight-word burst with ready high: back-to-back, in order.
    step();
    wr_ptr   = 9'd9;
    rd_ready = 1'b1;
    got = 0; bubbles = 0; started = 0;
    for (int c = 0; c < 20 && got < 8; c++) begin
      @(negedge clk);
      if (rd_valid) begin
        chk("burst_data", 32'(rd_data), 32'(got));
        got++;
        started = 1;
      end else if (started) begin
        bubbles++;
      end
      step();
    end
    chk("burst_count",   32'(got),     32'd8);
    chk("burst_bubbles", 32'(bubbles), 32'd0);
    @(negedge clk);
    chk("burst_rd_ptr", 32'(rd_ptr),   32'd9);
    chk("burst_level",  32'(level),    32'd0);
    chk("burst_idle",   32'(rd_valid), 32'd0);

    // Eight words with ready low: only two fetches, head held.
    step();
    wr_ptr   = 9'd17;
    rd_ready = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("stall_rd_ptr",   32'(rd_ptr),   32'd11);
    chk("stall_level",    32'(level),    32'd8);
    chk("stall_rd_valid", 32'(rd_valid), 32'd1);
    chk("stall_rd_data",  32'(rd_data),  32'd0);
    chk("stall_mem_ren",  32'(mem_ren),  32'd0);
`ifdef FIFO_RD_AE_EN
    chk("stall_almost_empty", 32'(almost_empty), 32'd0);
`endif
    repeat (3) step();
    @(negedge clk);
    chk("stall_hold_data", 32'(rd_data), 32'd0);
    chk("stall_hold_ptr",  32'(rd_ptr),  32'd11);

    step();
    rd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("release%0d_valid", k), 32'(rd_valid), 32'd1);
      chk($sformatf("release%0d_data", k),  32'(rd_data),  32'(k));
      chk($sformatf("release%0d_level", k), 32'(level),    32'(8 - k));
`ifdef FIFO_RD_AE_EN
      chk($sformatf("release%0d_ae", k), 32'(almost_empty), 32'((8 - k) <= 4));
`endif
      step();
    end
    @(negedge clk);
    chk("release_end_valid", 32'(rd_valid), 32'd0);
    chk("release_end_level", 32'(level),    32'd0);
    chk("release_end_ptr",   32'(rd_ptr),   32'd17);

    // Walk the pointer up to 0x1FE, then read across the address wrap.
    drain(9'h100);
    drain(9'h1FE);
    ram[8'hFE] = 8'h11;
    ram[8'hFF] = 8'h22;
    ram[8'h00] = 8'h33;
    ram[8'h01] = 8'h44;
    exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
    exp_wdat[0] = 8'h11; exp_wdat[1] = 8'h22; exp_wdat[2] = 8'h33; exp_wdat[3] = 8'h44;
    step();
    wr_ptr = 9'h002;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_ren) got_addr.push_back(mem_raddr);
      if (rd_valid && rd_ready) got_data.push_back(rd_data);
      step();
    end
    chk("wrap_fetches", 32'(got_addr.size()), 32'd4);
    chk("wrap_words",   32'(got_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_addr.size()) chk($sformatf("wrap_addr%0d", i), 32'(got_addr[i]), 32'(exp_addr[i]));
      if (i < got_data.size()) chk($sformatf("wrap_data%0d", i), 32'(got_data[i]), 32'(exp_wdat[i]));
    end
    @(negedge clk);
    chk("wrap_rd_ptr", 32'(rd_ptr), 32'h002);
    chk("wrap_level",  32'(level),  32'd0);

    // Reset with a full buffer discards everything immediately.
    step();
    wr_ptr   = 9'h006;
    rd_ready = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("prerst_valid",  32'(rd_valid), 32'd1);
    chk("prerst_rd_ptr", 32'(rd_ptr),   32'h004);
    chk("prerst_level",  32'(level),    32'd4);
    #1;
    rst_n  = 1'b0;
    wr_ptr = 9'd0;
    #1;
    chk("midrst_valid",  32'(rd_valid), 32'd0);
    chk("midrst_rd_ptr", 32'(rd_ptr),   32'd0);
    chk("midrst_level",  32'(level),    32'd0);
`ifdef FIFO_RD_AE_EN
    chk("midrst_ae", 32'(almost_empty), 32'd1);
`endif
    step();
    rst_n = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("postrst_valid",   32'(rd_valid), 32'd0);
    chk("postrst_mem_ren", 32'(mem_ren),  32'd0);
    chk("postrst_rd_ptr",  32'(rd_ptr),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
